// File: rtl/hdmi_i2c_init_seq.sv
// -----------------------------------------------------------------------------
// hdmi_i2c_init_seq
//
// Configuration sequencer for the HDMI transmitter. A start pulse or an hpd
// rising edge waits a power-up delay and then writes a fixed 10-entry register
// table to DEV_ADDR, one I2C register write per entry, through the byte-level
// I2C master's valid/ready command port. NACKed writes are retried after a
// gap; an entry that is still NACKed after MAX_RETRY retries ends the run in
// ERROR.
//
// Ports
//   clk         system clock (same domain as the master command port)
//   reset       asynchronous, active-low reset
//   start       one-cycle run request
//   hpd         hot-plug detect, already synchronized to clk
//   m_valid     command valid to the I2C master
//   m_ready     master accepts the command when high together with m_valid
//   m_dev_addr  device address, constant DEV_ADDR
//   m_reg       register address of the current entry
//   m_data      data byte of the current entry
//   m_done      one-cycle transfer-finished pulse from the master
//   m_nack      qualifies m_done: 1 = transfer was NACKed
//   busy        sequence in progress
//   done        all entries written (sticky until the next run)
//   error       an entry exhausted its retries (sticky until the next run)
//   idx         index of the current or last entry
// -----------------------------------------------------------------------------
module hdmi_i2c_init_seq #(
    parameter logic [6:0] DEV_ADDR       = 7'h39,
    parameter int         POWERUP_CYCLES = 50000,
    parameter int         RETRY_GAP      = 255,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hpd,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [6:0] m_dev_addr,
    output logic [7:0] m_reg,
    output logic [7:0] m_data,
    input  logic       m_done,
    input  logic       m_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] idx
);

    localparam int         RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [3:0] LAST_IDX = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PU,
        ISSUE,
        WAIT_XFER,
        GAP,
        DONE,
        ERROR
    } state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [RW-1:0] retry_cnt;
    logic          hpd_q;
    logic          trigger;

    // Register table as {reg, data}.
    function automatic logic [15:0] reg_entry(input logic [3:0] i);
        case (i)
            4'd0:    return 16'h41_10;
            4'd1:    return 16'h98_03;
            4'd2:    return 16'h9A_E0;
            4'd3:    return 16'h9C_30;
            4'd4:    return 16'h9D_61;
            4'd5:    return 16'hA2_A4;
            4'd6:    return 16'hA3_A4;
            4'd7:    return 16'hE0_D0;
            4'd8:    return 16'hF9_00;
            4'd9:    return 16'hAF_06;
            default: return 16'h00_00;
        endcase
    endfunction

    assign m_dev_addr = DEV_ADDR;

    // hpd_q resets low, so hpd held high out of reset is seen as a rising edge.
    // start and an hpd edge together form a single trigger.
    assign trigger = start | (hpd & ~hpd_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
            hpd_q     <= 1'b0;
            m_valid   <= 1'b0;
            m_reg     <= '0;
            m_data    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
        end else begin
            hpd_q <= hpd;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (trigger) begin
                        state     <= WAIT_PU;
                        idx       <= '0;
                        retry_cnt <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= 32'(POWERUP_CYCLES - 1);
                    end
                end

                WAIT_PU: begin
                    if (cnt == '0) begin
                        state            <= ISSUE;
                        m_valid          <= 1'b1;
                        {m_reg, m_data}  <= reg_entry(idx);
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end

                // m_done is not looked at here, so a pulse coinciding with
                // acceptance is dropped.
                ISSUE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= WAIT_XFER;
                    end
                end

                WAIT_XFER: begin
                    if (m_done) begin
                        if (!m_nack) begin
                            if (idx == LAST_IDX) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                idx             <= idx + 4'd1;
                                retry_cnt       <= '0;
                                state           <= ISSUE;
                                m_valid         <= 1'b1;
                                {m_reg, m_data} <= reg_entry(idx + 4'd1);
                            end
                        end else if (retry_cnt == RW'(MAX_RETRY)) begin
                            state <= ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= GAP;
                            cnt       <= 32'(RETRY_GAP - 1);
                        end
                    end
                end

                // m_reg/m_data still hold the failed entry, so only m_valid
                // needs to be raised again.
                GAP: begin
                    if (cnt == '0) begin
                        state   <= ISSUE;
                        m_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_init_seq.sv
// -----------------------------------------------------------------------------
// tb_hdmi_i2c_init_seq
//
// Self-checking bench for hdmi_i2c_init_seq. Expected write attempts
// (index, reg, data, and the ACK/NACK the bench master will answer with) are
// queued before each run; a small master model pops one per accepted command,
// compares it and answers with m_done five cycles later. Latencies of the
// power-up wait, the ACK/NACK follow-up and the end of the run are also
// checked.
// -----------------------------------------------------------------------------
module tb_hdmi_i2c_init_seq;

    localparam int         PU    = 20;
    localparam int         GAP_C = 7;
    localparam int         MR    = 3;
    localparam logic [6:0] DEV   = 7'h39;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       hpd;
    logic       m_valid;
    logic       m_ready;
    logic [6:0] m_dev_addr;
    logic [7:0] m_reg;
    logic [7:0] m_data;
    logic       m_done;
    logic       m_nack;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] idx;

    always #5 clk = ~clk;

    hdmi_i2c_init_seq #(
        .DEV_ADDR      (DEV),
        .POWERUP_CYCLES(PU),
        .RETRY_GAP     (GAP_C),
        .MAX_RETRY     (MR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hpd       (hpd),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_dev_addr(m_dev_addr),
        .m_reg     (m_reg),
        .m_data    (m_data),
        .m_done    (m_done),
        .m_nack    (m_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .idx       (idx)
    );

    typedef struct packed {
        logic [3:0] i;
        logic [7:0] r;
        logic [7:0] d;
        logic       nack;
    } exp_t;

    exp_t sb[$];

    logic [7:0] t_reg [10] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D,
                               8'hA2, 8'hA3, 8'hE0, 8'hF9, 8'hAF};
    logic [7:0] t_dat [10] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61,
                               8'hA4, 8'hA4, 8'hD0, 8'h00, 8'h06};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Queue the attempts of one run; nack_entry is NACKed nack_times times.
    // More NACKs than MAX_RETRY ends the run at that entry.
    task automatic push_seq(input int nack_entry, input int nack_times);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            if (i == nack_entry) begin
                for (int k = 0; k < nack_times && k <= MR; k++) begin
                    e = '{4'(i), t_reg[i], t_dat[i], 1'b1};
                    sb.push_back(e);
                end
                if (nack_times > MR) return;
            end
            e = '{4'(i), t_reg[i], t_dat[i], 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
    endtask

    // Master model. Runs until busy falls (or, with stop_entry, two cycles
    // after that entry is accepted). bp_entry is stalled for 20 cycles.
    task automatic run(input int bp_entry, input int stop_entry, input bit toggle_hpd,
                       output int first_valid);
        int         steps      = 0;
        int         dly        = -1;
        bit         pn         = 1'b0;
        int         done_step  = -1000;
        bit         done_nack  = 1'b0;
        bit         wait_valid = 1'b1;
        bit         acc_prev   = 1'b0;
        bit         saw_busy   = 1'b0;
        int         bp_left    = 20;
        bit         bp_seen    = 1'b0;
        bit         bp_ok      = 1'b1;
        logic [7:0] r0         = '0;
        logic [7:0] d0         = '0;
        int         stop_cnt   = -1;
        bit         finished   = 1'b0;
        exp_t       e;
        first_valid = -1;
        while (steps < 2000 && !finished) begin
            @(posedge clk); #1;
            steps++;
            start   = 1'b0;
            m_done  = 1'b0;
            m_nack  = 1'b0;
            m_ready = 1'b0;
            if (steps == 1)
                check("run_entry", 32'({busy, done, error, idx}), 32'({1'b1, 1'b0, 1'b0, 4'd0}));
            if (toggle_hpd && busy && (steps % 7 == 0)) hpd = ~hpd;
            if (acc_prev) check("valid_drop", 32'(m_valid), 32'd0);
            acc_prev = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    m_done     = 1'b1;
                    m_nack     = pn;
                    done_step  = steps;
                    done_nack  = pn;
                    wait_valid = 1'b1;
                    dly        = -1;
                end
            end
            if (busy) saw_busy = 1'b1;
            if (bp_seen && bp_left > 0 && !m_valid) bp_ok = 1'b0;
            if (stop_cnt > 0) begin
                stop_cnt--;
                if (stop_cnt == 0) finished = 1'b1;
            end else if (saw_busy && !busy) begin
                check("end_lat", 32'(steps - done_step), 32'd1);
                finished = 1'b1;
            end else if (m_valid) begin
                if (wait_valid) begin
                    wait_valid = 1'b0;
                    if (first_valid < 0) first_valid = steps;
                    else check("issue_lat", 32'(steps - done_step),
                               done_nack ? 32'(GAP_C + 1) : 32'd1);
                end
                if (int'(idx) == bp_entry && bp_left > 0) begin
                    if (!bp_seen) begin
                        bp_seen = 1'b1;
                        r0      = m_reg;
                        d0      = m_data;
                        // stray completion outside WAIT_XFER must be ignored
                        m_done  = 1'b1;
                        m_nack  = 1'b1;
                    end else if (m_reg !== r0 || m_data !== d0) begin
                        bp_ok = 1'b0;
                    end
                    bp_left--;
                    if (bp_left == 0) check("bp_stable", 32'(bp_ok), 32'd1);
                end else begin
                    m_ready  = 1'b1;
                    acc_prev = 1'b1;
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("accept", 32'({idx, m_reg, m_data}), 32'({e.i, e.r, e.d}));
                        dly = 5;
                        pn  = e.nack;
                        if (int'(idx) == stop_entry) stop_cnt = 2;
                    end
                end
            end
        end
        if (!finished) check("timeout", 32'd0, 32'd1);
        start   = 1'b0;
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        int fv;
        reset   = 1'b0;
        start   = 1'b0;
        hpd     = 1'b0;
        m_ready = 1'b0;
        m_done  = 1'b0;
        m_nack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'({m_valid, busy, done, error, idx, m_reg, m_data, m_dev_addr}),
              32'({4'b0000, 4'd0, 8'd0, 8'd0, DEV}));
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold", 32'({busy, m_valid}), 32'd0);

        // happy path
        push_seq(-1, 0);
        pulse_start();
        run(-1, -1, 1'b0, fv);
        check("pu_latency", 32'(fv), 32'(PU + 1));
        check("happy_end", 32'({done, busy, error, m_valid}), 32'b1000);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // backpressure on entry 3
        push_seq(-1, 0);
        pulse_start();
        run(3, -1, 1'b0, fv);
        check("bp_end", 32'({done, busy, error}), 32'b100);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // single NACK on entry 5
        push_seq(5, 1);
        pulse_start();
        run(-1, -1, 1'b0, fv);
        check("nack1_end", 32'({done, busy, error}), 32'b100);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // retry exhaustion on entry 7
        push_seq(7, MR + 1);
        pulse_start();
        run(-1, -1, 1'b0, fv);
        check("exhaust_end", 32'({error, done, busy, m_valid, idx}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd7}));
        check("sb_empty", 32'(sb.size()), 32'd0);

        // start after error reruns from entry 0
        push_seq(-1, 0);
        pulse_start();
        run(-1, -1, 1'b0, fv);
        check("rerun_end", 32'({done, busy, error}), 32'b100);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // hot-plug rising edge from DONE, hpd toggling while busy
        push_seq(-1, 0);
        @(posedge clk); #1;
        hpd = 1'b1;
        run(-1, -1, 1'b1, fv);
        check("hpd_latency", 32'(fv), 32'(PU + 1));
        check("hpd_end", 32'({done, busy, error}), 32'b100);
        check("sb_empty", 32'(sb.size()), 32'd0);
        hpd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hpd_fall", 32'({done, busy}), 32'b10);

        // reset during WAIT_XFER of entry 4
        push_seq(-1, 0);
        pulse_start();
        run(-1, 4, 1'b0, fv);
        check("pre_reset", 32'({busy, idx}), 32'({1'b1, 4'd4}));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 32'({m_valid, busy, done, error, idx, m_reg, m_data, m_dev_addr}),
              32'({4'b0000, 4'd0, 8'd0, 8'd0, DEV}));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_resume", 32'({busy, m_valid, done}), 32'd0);
        push_seq(-1, 0);
        pulse_start();
        run(-1, -1, 1'b0, fv);
        check("post_reset_lat", 32'(fv), 32'(PU + 1));
        check("post_reset_end", 32'({done, busy, error}), 32'b100);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hdmi_i2c_init_seq.md
# hdmi_i2c_init_seq

Configuration sequencer for the HDMI transmitter: after a start request or hot-plug event it waits a power-up delay, then walks a fixed register table and issues one I2C register write per entry to the byte-level I2C master over a valid/ready command interface. NACKed writes are retried with a gap; completion or failure is reported on status outputs. It sits between the top-level control logic and the I2C master, in the same clock domain as the master's command port.

## Interface
- DEV_ADDR, 7'h39, 7-bit I2C address of the transmitter.
- POWERUP_CYCLES, 50000, clk cycles waited before the first write (2 ms at 25 MHz); minimum 1.
- RETRY_GAP, 255, idle clk cycles between a NACK and the retry; minimum 1.
- MAX_RETRY, 3, retries allowed per entry after the first attempt.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the sequence.
- hpd  in  1  hot-plug detect, already synchronized to clk.
- m_valid  out  1  command valid to the I2C master.
- m_ready  in  1  master accepts the command when high with m_valid.
- m_dev_addr  out  7  device address, always DEV_ADDR.
- m_reg  out  8  register address of the current entry.
- m_data  out  8  data byte of the current entry.
- m_done  in  1  one-cycle pulse: transfer finished.
- m_nack  in  1  qualifies m_done: 1 = transfer NACKed.
- busy  out  1  sequence in progress.
- done  out  1  all entries written; sticky until next run.
- error  out  1  an entry exhausted its retries; sticky until next run.
- idx  out  4  index of the current or last entry.

## Operation
- Table, 10 entries, index 0..9, as reg=data: 41=10, 98=03, 9A=E0, 9C=30, 9D=61, A2=A4, A3=A4, E0=D0, F9=00, AF=06.
- States: IDLE, WAIT_PU, ISSUE, WAIT_XFER, GAP, DONE, ERROR.
- IDLE/DONE/ERROR: start, or an hpd rising edge (hpd high, previous-cycle hpd low), moves to WAIT_PU. On entering WAIT_PU: clear idx, retry count, done and error; load the delay counter.
- WAIT_PU: count POWERUP_CYCLES cycles, then go to ISSUE.
- ISSUE: m_valid=1 with m_reg/m_data from table[idx]. Hold the fields stable until m_valid&&m_ready, then go to WAIT_XFER.
- WAIT_XFER: wait for m_done.
  - m_done with m_nack=0: if idx==9, go to DONE. Otherwise increment idx, clear the retry count and go to ISSUE.
  - m_done with m_nack=1: if retry count==MAX_RETRY, go to ERROR. Otherwise increment the retry count and go to GAP.
- GAP: count RETRY_GAP cycles, then go to ISSUE with the same idx.
- busy=1 in WAIT_PU, ISSUE, WAIT_XFER and GAP.
- done=1 only in DONE; error=1 only in ERROR.
- In ERROR, idx holds the failing entry.
- Ignored inputs:
  - start and hpd edges while busy; hpd falling edges in every state.
  - m_done outside WAIT_XFER.
  - m_nack without m_done.

## Timing
- Reset (async, low):
  - state=IDLE; m_valid, busy, done, error = 0; idx=0; m_reg=m_data=0; m_dev_addr=DEV_ADDR.
  - The hpd edge register resets to 0. hpd held high out of reset therefore counts as a rising edge.
- Reset mid-operation drops m_valid immediately. The sequence does not resume; a fresh start is needed.
- start high in cycle N: busy=1 from N+1, and the first m_valid rises at N+1+POWERUP_CYCLES.
- Accept in cycle A (m_valid&&m_ready): m_valid=0 from A+1.
- m_done (ACK) in cycle D: m_valid for the next entry is high at D+1 with updated idx/m_reg/m_data.
- m_done (ACK) on the last entry in cycle D: done=1 and busy=0 at D+1.
- m_done (NACK) in cycle D: m_valid is high again at D+1+RETRY_GAP, or error=1 at D+1 if retries are exhausted.
- m_done in the same cycle as acceptance is not legal from the master. It is ignored.
- start and an hpd edge in the same cycle count as one trigger.
- Total attempts per entry = MAX_RETRY+1.

## Test plan
- Happy path: reset, start pulse, master ACKs every write after 5 cycles -> 10 accepts with (reg,data) in table order (41/10 ... AF/06); first m_valid exactly POWERUP_CYCLES+1 cycles after start; done=1, busy=0.
- Backpressure: m_ready held low 20 cycles on entry 3 -> m_valid stays high, m_reg=9C and m_data=30 stable throughout, one accept only.
- Single NACK: entry 5 NACKed once -> gap of RETRY_GAP cycles, A2/A4 reissued, sequence finishes with done=1, error=0.
- Retry exhaustion: entry 7 always NACKed -> 4 attempts on E0/D0, then error=1, idx=7, busy=0, m_valid=0; a following start clears error and reruns from idx 0.
- Hot-plug: hpd rises while in DONE -> done clears and the full sequence reruns; hpd toggling while busy has no effect.
- Mid-run reset: assert reset during WAIT_XFER of entry 4 -> all outputs at reset values at once; start afterwards begins at entry 0.
